prio_arb: RTL and testbench
===========================

Name: prio_arb

Overview:
- Parametrised, registered successor to the team's combinational 4-to-2 priority encoder.
- Arbitrates N request lines and issues one locked grant at a time, as both a one-hot vector and a binary index.
- Supports fixed-priority mode (highest or lowest index wins) and round-robin mode.
- Sits in front of shared resources (bus ports, memory banks); clients hold the grant until they pulse done.

Parameters:
- N, 8: number of requesters; must be >= 2.
- MODE, ARB_FIXED: arb_mode_e; ARB_FIXED or ARB_RR.
- HIGH_FIRST, 1: fixed mode only. 1 = highest index wins; 0 = lowest index wins.
- IW, $clog2(N): derived grant index width; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request lines; bit i = client i.
- done  input  1  pulse from the current grant holder to release the grant.
- gnt_valid  output  1  a grant is active.
- gnt_oh  output  N  one-hot grant; all zero when gnt_valid=0.
- gnt_idx  output  IW  binary index of the grant holder; 0 when gnt_valid=0.

Behaviour:
- All outputs are registered.
- Reset, asynchronous and immediate: state=IDLE, gnt_valid=0, gnt_oh=0, gnt_idx=0, rr_ptr=0.
- FSM has two states, IDLE and GRANT.
- IDLE, req != 0: next edge enters GRANT; gnt_valid=1; gnt_oh and gnt_idx show the winner. Latency is 1 cycle from req seen to grant visible.
- IDLE, req == 0: stay in IDLE; outputs stay zero.
- GRANT, done=0: grant is locked and outputs hold.
  - Outputs hold even if req[gnt_idx] drops or higher-priority requests arrive; there is no preemption.
- GRANT, done=1, req != 0: re-arbitrate on this cycle's req and load the new winner at the next edge.
  - Back-to-back grants have no bubble cycle.
  - The releasing client's own req bit is included in that arbitration.
- GRANT, done=1, req == 0: next edge returns to IDLE and outputs go to zero.
- done in IDLE is ignored.
- Fixed-mode winner:
  - HIGH_FIRST=1: highest set index of req; for N=4 this matches the legacy encoder.
  - HIGH_FIRST=0: lowest set index of req.
- Round-robin winner: first set bit searching upward from rr_ptr, wrapping N-1 to 0.
  - rr_ptr updates to (winner+1) mod N on every grant load.
  - Winner N-1 gives rr_ptr=0 (wrap).
  - rr_ptr is unchanged while locked or idle.
- Invariant: gnt_oh == (1 << gnt_idx) when gnt_valid=1; gnt_oh is zero otherwise.
- Reset asserted mid-grant clears the grant immediately with no done required; rr_ptr returns to 0.
- X on req while IDLE is not allowed; bench assertion flags it.

Decomposition:
- Shared package prio_pkg holds:
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR};
  - typedef enum arb_state_e {ARB_IDLE, ARB_GRANT};
  - function onehot2idx.
- Sub-module prio_enc_n: parametrised combinational priority encoder.
  - Parameters N and HIGH_FIRST.
  - Outputs any, idx, onehot.
- RR mode uses two prio_enc_n instances with HIGH_FIRST=0:
  - one on req masked to bits >= rr_ptr;
  - one on unmasked req as the wrap fallback.
  - The masked result wins when its any=1.
- prio_arb holds the FSM, rr_ptr and output registers.

Test Plan:
- Reset: assert rst mid-grant (N=8, gnt_idx=5) -> same cycle gnt_valid=0, gnt_oh=0, gnt_idx=0; after release with req=0, outputs stay zero.
- Fixed, HIGH_FIRST=1, N=4: req=4'b0110 -> one cycle later gnt_idx=2, gnt_oh=4'b0100. Raise req[3] while locked -> grant unchanged until done. On done with req=4'b1010 -> next cycle gnt_idx=3.
- Fixed, HIGH_FIRST=0, N=8: req=8'b1001_0000 -> gnt_idx=4. done with req=0 -> next cycle gnt_valid=0.
- RR, N=4, req held at 4'b1111 with done each grant cycle -> grant sequence 0,1,2,3,0 with no bubbles; rr_ptr wraps to 0 after index 3.
- RR, N=8, rr_ptr=6, req=8'b0000_0101 -> wrap search gives gnt_idx=0, then rr_ptr=1. Next done with req unchanged -> gnt_idx=2.
- Release/idle: done pulsed while IDLE -> no state change. Grant holder drops req but withholds done for 10 cycles -> grant held all 10 cycles.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the priority arbiter and its encoder.
package prio_pkg;

    localparam int unsigned MAX_N = 32;

    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_e;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

    function automatic int unsigned onehot2idx(input logic [MAX_N-1:0] oh);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) r = i;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Parametrised combinational priority encoder: highest or lowest set bit wins.
module prio_enc_n
    import prio_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter bit          HIGH_FIRST = 1'b1,
    localparam int unsigned IW        = $clog2(N)
) (
    input  logic [N-1:0]  req,
    output logic          any,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        // Scan toward the winning end so the last hit overwrites earlier ones.
        if (HIGH_FIRST) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (req[i]) begin
                    onehot    = '0;
                    onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = N; i > 0; i--) begin
                if (req[i-1]) begin
                    onehot      = '0;
                    onehot[i-1] = 1'b1;
                end
            end
        end
    end

    assign any = |req;
    assign idx = IW'(onehot2idx(MAX_N'(onehot)));

endmodule

// File: rtl/prio_arb.sv
// Registered N-way arbiter: fixed-priority or round-robin, grant locked until done.
module prio_arb
    import prio_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter arb_mode_e   MODE       = ARB_FIXED,
    parameter bit          HIGH_FIRST = 1'b1,
    parameter int unsigned IW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic          gnt_valid,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx
);

    arb_state_e    state, state_nxt;
    logic          load;
    logic          clear;
    logic          win_any;
    logic [IW-1:0] win_idx;
    logic [N-1:0]  win_oh;

    if (MODE == ARB_RR) begin : g_rr
        logic [IW-1:0] rr_ptr;
        logic [N-1:0]  rr_mask;
        logic          m_any, u_any;
        logic [IW-1:0] m_idx, u_idx;
        logic [N-1:0]  m_oh, u_oh;

        always_comb begin
            rr_mask = '0;
            for (int unsigned i = 0; i < N; i++) begin
                rr_mask[i] = (i >= 32'(rr_ptr));
            end
        end

        prio_enc_n #(.N(N), .HIGH_FIRST(1'b0)) u_enc_masked (
            .req    (req & rr_mask),
            .any    (m_any),
            .idx    (m_idx),
            .onehot (m_oh)
        );

        prio_enc_n #(.N(N), .HIGH_FIRST(1'b0)) u_enc_wrap (
            .req    (req),
            .any    (u_any),
            .idx    (u_idx),
            .onehot (u_oh)
        );

        // Nothing at or above the pointer means the search wraps to bit 0.
        assign win_any = m_any | u_any;
        assign win_idx = m_any ? m_idx : u_idx;
        assign win_oh  = m_any ? m_oh  : u_oh;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rr_ptr <= '0;
            end else if (load) begin
                rr_ptr <= (win_idx == IW'(N-1)) ? '0 : win_idx + 1'b1;
            end
        end
    end else begin : g_fixed
        prio_enc_n #(.N(N), .HIGH_FIRST(HIGH_FIRST)) u_enc (
            .req    (req),
            .any    (win_any),
            .idx    (win_idx),
            .onehot (win_oh)
        );
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        clear     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (win_any) begin
                    load      = 1'b1;
                    state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (done) begin
                    if (win_any) begin
                        load = 1'b1;
                    end else begin
                        clear     = 1'b1;
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB_IDLE;
            gnt_valid <= 1'b0;
            gnt_oh    <= '0;
            gnt_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                gnt_valid <= 1'b1;
                gnt_oh    <= win_oh;
                gnt_idx   <= win_idx;
            end else if (clear) begin
                gnt_valid <= 1'b0;
                gnt_oh    <= '0;
                gnt_idx   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_arb.sv
// Scoreboard bench for prio_arb across fixed-high, fixed-low and round-robin configurations.
module tb_prio_arb;
    import prio_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // u0: N=8 fixed high, u1: N=4 fixed high, u2: N=8 fixed low, u3: N=4 RR, u4: N=8 RR
    logic [7:0] req0 = '0, req2 = '0, req4 = '0;
    logic [3:0] req1 = '0, req3 = '0;
    logic       done0 = 1'b0, done1 = 1'b0, done2 = 1'b0, done3 = 1'b0, done4 = 1'b0;
    logic       gv0, gv1, gv2, gv3, gv4;
    logic [7:0] oh0, oh2, oh4;
    logic [3:0] oh1, oh3;
    logic [2:0] ix0, ix2, ix4;
    logic [1:0] ix1, ix3;

    prio_arb #(.N(8), .MODE(ARB_FIXED), .HIGH_FIRST(1'b1)) u0 (
        .clk(clk), .rst(rst), .req(req0), .done(done0),
        .gnt_valid(gv0), .gnt_oh(oh0), .gnt_idx(ix0));
    prio_arb #(.N(4), .MODE(ARB_FIXED), .HIGH_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .req(req1), .done(done1),
        .gnt_valid(gv1), .gnt_oh(oh1), .gnt_idx(ix1));
    prio_arb #(.N(8), .MODE(ARB_FIXED), .HIGH_FIRST(1'b0)) u2 (
        .clk(clk), .rst(rst), .req(req2), .done(done2),
        .gnt_valid(gv2), .gnt_oh(oh2), .gnt_idx(ix2));
    prio_arb #(.N(4), .MODE(ARB_RR), .HIGH_FIRST(1'b0)) u3 (
        .clk(clk), .rst(rst), .req(req3), .done(done3),
        .gnt_valid(gv3), .gnt_oh(oh3), .gnt_idx(ix3));
    prio_arb #(.N(8), .MODE(ARB_RR), .HIGH_FIRST(1'b0)) u4 (
        .clk(clk), .rst(rst), .req(req4), .done(done4),
        .gnt_valid(gv4), .gnt_oh(oh4), .gnt_idx(ix4));

    always @(posedge clk) begin
        if (!rst) begin
            assert (!$isunknown({req0, req1, req2, req3, req4}))
                else $error("X on req");
        end
    end

    typedef struct {
        int         id;
        int         due;
        logic       v;
        logic [2:0] idx;
        logic [7:0] oh;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    exp_t       e;
    logic       av;
    logic [2:0] ai;
    logic [7:0] ao;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            case (e.id)
                0: begin av = gv0; ai = ix0;        ao = oh0;        end
                1: begin av = gv1; ai = {1'b0, ix1}; ao = {4'h0, oh1}; end
                2: begin av = gv2; ai = ix2;        ao = oh2;        end
                3: begin av = gv3; ai = {1'b0, ix3}; ao = {4'h0, oh3}; end
                default: begin av = gv4; ai = ix4; ao = oh4; end
            endcase
            checks++;
            if (av !== e.v || ai !== e.idx || ao !== e.oh) begin
                errors++;
                $display("FAIL %s (u%0d): valid/idx/oh actual %b/%0d/%b required %b/%0d/%b",
                         e.name, e.id, av, ai, ao, e.v, e.idx, e.oh);
            end
        end
    end

    function automatic exp_t mk(input int id, input int due, input logic v,
                                input logic [2:0] i, input string nm);
        exp_t x;
        x.id   = id;
        x.due  = due;
        x.v    = v;
        x.idx  = i;
        x.oh   = v ? (8'd1 << i) : 8'd0;
        x.name = nm;
        return x;
    endfunction

    // Drive one DUT at a negedge; its expected outputs are due after the next posedge.
    task automatic step(input int id, input logic [7:0] r, input logic d,
                        input logic ev, input logic [2:0] ei, input string nm);
        case (id)
            0: begin req0 = r;      done0 = d; end
            1: begin req1 = r[3:0]; done1 = d; end
            2: begin req2 = r;      done2 = d; end
            3: begin req3 = r[3:0]; done3 = d; end
            default: begin req4 = r; done4 = d; end
        endcase
        sb.push_back(mk(id, cyc + 1, ev, ei, nm));
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) step(k, 8'h00, 1'b0, 1'b0, 3'd0, "idle_zero");

        // Fixed, highest index wins, N=4
        step(1, 8'b0110, 1'b0, 1'b1, 3'd2, "fhi_first");
        step(1, 8'b1110, 1'b0, 1'b1, 3'd2, "fhi_lock_hi_arrives");
        step(1, 8'b1110, 1'b0, 1'b1, 3'd2, "fhi_lock_hold");
        step(1, 8'b1010, 1'b1, 1'b1, 3'd3, "fhi_done_rearb");
        step(1, 8'b0000, 1'b1, 1'b0, 3'd0, "fhi_release");

        // Fixed, lowest index wins, N=8
        step(2, 8'b1001_0000, 1'b0, 1'b1, 3'd4, "flo_first");
        step(2, 8'b1001_0000, 1'b1, 1'b1, 3'd4, "flo_own_req_rearb");
        step(2, 8'b0000_0000, 1'b1, 1'b0, 3'd0, "flo_release");
        step(2, 8'b0000_0000, 1'b1, 1'b0, 3'd0, "flo_done_in_idle");
        step(2, 8'b1000_0001, 1'b0, 1'b1, 3'd0, "flo_bit0");
        for (int k = 0; k < 10; k++) step(2, 8'h00, 1'b0, 1'b1, 3'd0, "flo_hold_no_done");
        step(2, 8'h00, 1'b1, 1'b0, 3'd0, "flo_release2");

        // Round-robin, N=4, all requesting, done every grant cycle
        step(3, 8'b1111, 1'b0, 1'b1, 3'd0, "rr4_g0");
        step(3, 8'b1111, 1'b1, 1'b1, 3'd1, "rr4_g1");
        step(3, 8'b1111, 1'b1, 1'b1, 3'd2, "rr4_g2");
        step(3, 8'b1111, 1'b1, 1'b1, 3'd3, "rr4_g3");
        step(3, 8'b1111, 1'b1, 1'b1, 3'd0, "rr4_wrap_g0");
        step(3, 8'b0000, 1'b1, 1'b0, 3'd0, "rr4_release");

        // Round-robin, N=8: grant 5 leaves pointer at 6, then wrap search
        step(4, 8'b0010_0000, 1'b0, 1'b1, 3'd5, "rr8_g5");
        step(4, 8'b0000_0101, 1'b1, 1'b1, 3'd0, "rr8_wrap_g0");
        step(4, 8'b0000_0101, 1'b1, 1'b1, 3'd2, "rr8_g2");
        step(4, 8'b0000_0000, 1'b1, 1'b0, 3'd0, "rr8_release");

        // Reset in the middle of a locked grant
        step(0, 8'b0010_0000, 1'b0, 1'b1, 3'd5, "rst_pre_g5");
        step(0, 8'b1111_1111, 1'b0, 1'b1, 3'd5, "rst_pre_hold");
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.push_back(mk(0, cyc, 1'b0, 3'd0, "rst_async_clear"));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(0, 8'h00, 1'b0, 1'b0, 3'd0, "rst_post_idle");
        step(0, 8'h00, 1'b0, 1'b0, 3'd0, "rst_post_idle2");

        // Round-robin pointer back to 0 after reset: 1001 must pick 0, not 3
        step(3, 8'b1001, 1'b0, 1'b1, 3'd0, "rr4_ptr_reset");
        step(3, 8'b0000, 1'b1, 1'b0, 3'd0, "rr4_ptr_release");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending actual %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
